// File: rtl/write_master_port.sv
// Write-side front end of one AXI interconnect master slot: it allocates IDs and sequences AW, W and B against write_arbiter.
// Optional feature: define WMP_ERR_CNT_EN to build the saturating error-response counter on err_cnt.
module write_master_port #(
    parameter int ADDR_WIDTH            = 32,
    parameter int DATA_WIDTH            = 32,
    parameter int NUM_OUTSTANDING_TRANS = 2,
    localparam int IDW                  = $clog2(NUM_OUTSTANDING_TRANS)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_len,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    output logic                  AW_valid,
    output logic [ADDR_WIDTH-1:0] AW_addr,
    output logic [IDW-1:0]        AW_id,
    input  logic                  AW_grant,
    output logic [IDW-1:0]        W_id,
    output logic                  B_ready,
    input  logic                  W_grant,
    output logic [DATA_WIDTH-1:0] W_data,
    output logic                  W_valid,
    output logic                  W_last,
    input  logic                  W_ready,
    input  logic                  B_valid,
    input  logic [1:0]            B_resp,
    output logic                  done_valid,
    output logic [IDW-1:0]        done_id,
    output logic [1:0]            done_resp,
    output logic [7:0]            err_cnt,
    output logic [2:0]            dbg_state_o
);

    // Handshake rule on every valid/ready pair here: a transfer happens on a rising clk edge where
    // both are high; valid, once raised, holds its payload stable until that edge.

    localparam logic [0:0] AW_IDLE = 1'b0;
    localparam logic [0:0] AW_REQ  = 1'b1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_REQ  = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    localparam int            CW      = IDW + 1;
    localparam logic [CW-1:0] MAX_OUT = CW'(NUM_OUTSTANDING_TRANS);

    logic [0:0]            aw_state_q, aw_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]            aw_len_q, aw_len_d;
    logic [IDW-1:0]        aw_id_q, aw_id_d;
    logic [IDW-1:0]        next_id_q, next_id_d;
    logic                  ready_en_q;

    logic [IDW-1:0]        q_id_q  [NUM_OUTSTANDING_TRANS];
    logic [7:0]            q_len_q [NUM_OUTSTANDING_TRANS];
    logic [IDW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         occ_q, occ_d;

    logic [1:0]            w_state_q, w_state_d;
    logic [IDW-1:0]        w_id_q, w_id_d;
    logic [7:0]            cnt_q, cnt_d;

    logic                  done_valid_q;
    logic [IDW-1:0]        done_id_q;
    logic [1:0]            done_resp_q;

    logic aw_pending, req_hs, aw_hs, w_hs, b_done, in_data;

    assign aw_pending = (aw_state_q == AW_REQ);
    assign req_ready  = ready_en_q && (aw_state_q == AW_IDLE)
                        && ((occ_q + CW'(aw_pending)) < MAX_OUT);
    assign req_hs     = req_valid && req_ready;
    assign aw_hs      = (aw_state_q == AW_REQ) && AW_grant;
    assign in_data    = (w_state_q == W_DATA);
    assign w_hs       = in_data && wdata_valid && W_ready;
    assign b_done     = (w_state_q == W_RESP) && B_valid;

    always_comb begin
        aw_state_d = aw_state_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_id_d    = aw_id_q;
        next_id_d  = next_id_q;
        case (aw_state_q)
            AW_IDLE: begin
                if (req_hs) begin
                    aw_addr_d  = req_addr;
                    aw_len_d   = req_len;
                    aw_id_d    = next_id_q;
                    next_id_d  = next_id_q + IDW'(1);
                    aw_state_d = AW_REQ;
                end
            end
            AW_REQ: begin
                if (AW_grant) aw_state_d = AW_IDLE;
            end
            default: aw_state_d = AW_IDLE;
        endcase
    end

    // The W side reads the queue head without popping; the entry leaves only when B completes.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        cnt_d     = cnt_q;
        case (w_state_q)
            W_IDLE: begin
                if (occ_q != '0) begin
                    w_id_d    = q_id_q[rd_ptr_q];
                    cnt_d     = q_len_q[rd_ptr_q];
                    w_state_d = W_REQ;
                end
            end
            W_REQ: begin
                if (W_grant) w_state_d = W_DATA;
            end
            W_DATA: begin
                if (w_hs) begin
                    if (cnt_q == 8'd0) w_state_d = W_RESP;
                    else               cnt_d     = cnt_q - 8'd1;
                end
            end
            W_RESP: begin
                if (B_valid) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign occ_d = occ_q + CW'(aw_hs) - CW'(b_done);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            aw_state_q   <= AW_IDLE;
            aw_addr_q    <= '0;
            aw_len_q     <= '0;
            aw_id_q      <= '0;
            next_id_q    <= '0;
            ready_en_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            w_state_q    <= W_IDLE;
            w_id_q       <= '0;
            cnt_q        <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            done_resp_q  <= '0;
        end else begin
            aw_state_q   <= aw_state_d;
            aw_addr_q    <= aw_addr_d;
            aw_len_q     <= aw_len_d;
            aw_id_q      <= aw_id_d;
            next_id_q    <= next_id_d;
            ready_en_q   <= 1'b1;
            occ_q        <= occ_d;
            w_state_q    <= w_state_d;
            w_id_q       <= w_id_d;
            cnt_q        <= cnt_d;
            done_valid_q <= b_done;
            if (aw_hs)  wr_ptr_q <= wr_ptr_q + IDW'(1);
            if (b_done) begin
                rd_ptr_q    <= rd_ptr_q + IDW'(1);
                done_id_q   <= w_id_q;
                done_resp_q <= B_resp;
            end
        end
    end

    // Storage is qualified by occupancy, so it needs no reset.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            q_id_q[wr_ptr_q]  <= aw_id_q;
            q_len_q[wr_ptr_q] <= aw_len_q;
        end
    end

`ifdef WMP_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err_cnt_q <= '0;
        end else if (b_done && (B_resp != 2'b00) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign AW_valid    = (aw_state_q == AW_REQ);
    assign AW_addr     = aw_addr_q;
    assign AW_id       = aw_id_q;
    assign W_id        = w_id_q;
    assign B_ready     = (w_state_q != W_IDLE);
    assign W_valid     = in_data && wdata_valid;
    assign W_data      = in_data ? wdata : '0;
    assign wdata_ready = in_data && W_ready;
    assign W_last      = in_data && (cnt_q == 8'd0);
    assign done_valid  = done_valid_q;
    assign done_id     = done_id_q;
    assign done_resp   = done_resp_q;
    assign dbg_state_o = {aw_state_q, w_state_q};

endmodule

// File: tb/tb_write_master_port.sv
// Directed bench for write_master_port: arbiter grants and slave responses are driven by hand,
// with a completion scoreboard. Expectations for err_cnt follow WMP_ERR_CNT_EN.
module tb_write_master_port;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int N   = 2;
    localparam int IDW = 1;
    localparam int EW  = IDW + 2;

    logic           clk = 1'b0;
    logic           clr = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [AW-1:0]  req_addr = '0;
    logic [7:0]     req_len = '0;
    logic [DW-1:0]  wdata = '0;
    logic           wdata_valid = 1'b0;
    logic           wdata_ready;
    logic           AW_valid;
    logic [AW-1:0]  AW_addr;
    logic [IDW-1:0] AW_id;
    logic           AW_grant = 1'b0;
    logic [IDW-1:0] W_id;
    logic           B_ready;
    logic           W_grant = 1'b0;
    logic [DW-1:0]  W_data;
    logic           W_valid;
    logic           W_last;
    logic           W_ready = 1'b0;
    logic           B_valid = 1'b0;
    logic [1:0]     B_resp = '0;
    logic           done_valid;
    logic [IDW-1:0] done_id;
    logic [1:0]     done_resp;
    logic [7:0]     err_cnt;
    logic [2:0]     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int hs_base;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] sb_e;

    write_master_port #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_OUTSTANDING_TRANS(N)
    ) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .AW_valid(AW_valid), .AW_addr(AW_addr), .AW_id(AW_id), .AW_grant(AW_grant),
        .W_id(W_id), .B_ready(B_ready), .W_grant(W_grant),
        .W_data(W_data), .W_valid(W_valid), .W_last(W_last), .W_ready(W_ready),
        .B_valid(B_valid), .B_resp(B_resp),
        .done_valid(done_valid), .done_id(done_id), .done_resp(done_resp),
        .err_cnt(err_cnt), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completion pulse must match the oldest expected {id, resp}.
    always @(negedge clk) begin
        if (clr && done_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_done_unexpected", 1, 0);
            end else begin
                sb_e = exp_q.pop_front();
                check_eq("sb_done_id", done_id, sb_e[EW-1:2]);
                check_eq("sb_done_resp", done_resp, sb_e[1:0]);
            end
        end
        if (W_valid && W_ready) hs_cnt++;
    end

    task automatic drive_idle();
        req_valid = 0; AW_grant = 0; W_grant = 0; wdata_valid = 0;
        W_ready = 0; B_valid = 0; B_resp = 0; wdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_AW_valid"}, AW_valid, 0);
        check_eq({tag, "_AW_addr"}, AW_addr, 0);
        check_eq({tag, "_AW_id"}, AW_id, 0);
        check_eq({tag, "_W_id"}, W_id, 0);
        check_eq({tag, "_B_ready"}, B_ready, 0);
        check_eq({tag, "_W_valid"}, W_valid, 0);
        check_eq({tag, "_W_last"}, W_last, 0);
        check_eq({tag, "_W_data"}, W_data, 0);
        check_eq({tag, "_wdata_ready"}, wdata_ready, 0);
        check_eq({tag, "_done_valid"}, done_valid, 0);
        check_eq({tag, "_done_id"}, done_id, 0);
        check_eq({tag, "_done_resp"}, done_resp, 0);
        check_eq({tag, "_err_cnt"}, err_cnt, 0);
        check_eq({tag, "_req_ready"}, req_ready, 0);
    endtask

    task automatic apply_reset(input string tag);
        drive_idle();
        clr = 0;
        #1;
        check_all_zero(tag);
        tick();
        tick();
        clr = 1;
        #1;
        check_eq({tag, "_ready_at_release"}, req_ready, 0);
        tick();
        check_eq({tag, "_ready_after_release"}, req_ready, 1);
    endtask

    // One complete transaction from idle: AW with one stalled cycle, W burst, B response.
    task automatic run_write(input string tag, input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [1:0] resp, input logic [IDW-1:0] exp_id);
        check_eq({tag, "_req_ready"}, req_ready, 1);
        req_valid = 1; req_addr = addr; req_len = len;
        tick();
        req_valid = 0;
        check_eq({tag, "_aw_valid"}, AW_valid, 1);
        check_eq({tag, "_aw_id"}, AW_id, exp_id);
        check_eq({tag, "_aw_addr"}, AW_addr, addr);
        check_eq({tag, "_ready_in_aw"}, req_ready, 0);
        tick();
        check_eq({tag, "_aw_hold"}, AW_valid, 1);
        AW_grant = 1;
        tick();
        AW_grant = 0;
        check_eq({tag, "_aw_drop"}, AW_valid, 0);
        check_eq({tag, "_bready_early"}, B_ready, 0);
        wdata_valid = 1; W_ready = 1; wdata = 32'hDEAD_BEEF;
        tick();
        check_eq({tag, "_bready_wreq"}, B_ready, 1);
        check_eq({tag, "_w_id"}, W_id, exp_id);
        check_eq({tag, "_wready_gated"}, wdata_ready, 0);
        check_eq({tag, "_wvalid_gated"}, W_valid, 0);
        W_grant = 1;
        tick();
        W_grant = 0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = addr ^ DW'(i);
            #1;
            check_eq({tag, "_beat_valid"}, W_valid, 1);
            check_eq({tag, "_beat_data"}, W_data, addr ^ DW'(i));
            check_eq({tag, "_beat_last"}, W_last, (i == int'(len)) ? 1 : 0);
            check_eq({tag, "_beat_ready"}, wdata_ready, 1);
            tick();
        end
        #1;
        check_eq({tag, "_resp_wvalid"}, W_valid, 0);
        check_eq({tag, "_resp_wready"}, wdata_ready, 0);
        check_eq({tag, "_resp_bready"}, B_ready, 1);
        wdata_valid = 0; W_ready = 0;
        exp_q.push_back({exp_id, resp});
        B_valid = 1; B_resp = resp;
        tick();
        B_valid = 0; B_resp = 0;
        check_eq({tag, "_done_pulse"}, done_valid, 1);
        check_eq({tag, "_done_id"}, done_id, exp_id);
        check_eq({tag, "_done_resp"}, done_resp, resp);
        tick();
        check_eq({tag, "_done_drop"}, done_valid, 0);
        check_eq({tag, "_bready_idle"}, B_ready, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        // Single 4-beat write.
        apply_reset("rst0");
        run_write("single", 32'h0001_0010, 8'd3, 2'b00, 1'b0);

        // Two back-to-back requests, then a third that stalls until the first completes.
        apply_reset("rst1");
        req_valid = 1; req_addr = 32'h0000_0A00; req_len = 8'd0;
        tick();
        check_eq("b2b_aw0_id", AW_id, 0);
        check_eq("b2b_aw0_valid", AW_valid, 1);
        AW_grant = 1; req_addr = 32'h0000_0B00; req_len = 8'd1;
        tick();
        AW_grant = 0;
        check_eq("b2b_gap_awvalid", AW_valid, 0);
        check_eq("b2b_ready_occ1", req_ready, 1);
        tick();
        check_eq("b2b_aw1_id", AW_id, 1);
        check_eq("b2b_aw1_addr", AW_addr, 32'h0000_0B00);
        check_eq("b2b_aw1_valid", AW_valid, 1);
        check_eq("b2b_wid0", W_id, 0);
        check_eq("b2b_bready0", B_ready, 1);
        req_addr = 32'h0000_0C00; req_len = 8'd0;
        AW_grant = 1;
        tick();
        AW_grant = 0;
        check_eq("full_ready0", req_ready, 0);
        tick();
        check_eq("full_ready1", req_ready, 0);
        check_eq("full_aw_hold", AW_valid, 0);
        W_grant = 1;
        tick();
        W_grant = 0;
        wdata_valid = 1; W_ready = 1; wdata = 32'h1111_0000;
        #1;
        check_eq("b2b_w0_last", W_last, 1);
        check_eq("full_ready2", req_ready, 0);
        tick();
        wdata_valid = 0; W_ready = 0;
        exp_q.push_back({1'b0, 2'b00});
        B_valid = 1; B_resp = 2'b00;
        check_eq("full_ready3", req_ready, 0);
        tick();
        B_valid = 0;
        check_eq("b2b_done0", done_valid, 1);
        check_eq("b2b_done0_id", done_id, 0);
        check_eq("wrap_ready", req_ready, 1);
        tick();
        req_valid = 0;
        check_eq("wrap_aw_id", AW_id, 0);
        check_eq("wrap_aw_addr", AW_addr, 32'h0000_0C00);
        check_eq("wrap_aw_valid", AW_valid, 1);
        check_eq("b2b_wid1", W_id, 1);
        check_eq("b2b_done_drop", done_valid, 0);
        AW_grant = 1;
        tick();
        AW_grant = 0;
        W_grant = 1;
        tick();
        W_grant = 0;
        for (int i = 0; i < 2; i++) begin
            wdata_valid = 1; W_ready = 1; wdata = 32'h2222_0000 + DW'(i);
            #1;
            check_eq("b2b_w1_last", W_last, (i == 1) ? 1 : 0);
            check_eq("b2b_w1_data", W_data, 32'h2222_0000 + DW'(i));
            tick();
        end
        wdata_valid = 0; W_ready = 0;
        exp_q.push_back({1'b1, 2'b10});
        B_valid = 1; B_resp = 2'b10;
        tick();
        B_valid = 0; B_resp = 0;
        check_eq("b2b_done1_id", done_id, 1);
        check_eq("b2b_done1_resp", done_resp, 2'b10);
        tick();
        check_eq("wrap_wid", W_id, 0);
        check_eq("wrap_bready", B_ready, 1);
        W_grant = 1;
        tick();
        W_grant = 0;
        wdata_valid = 1; W_ready = 1; wdata = 32'h3333_0000;
        #1;
        check_eq("wrap_w_last", W_last, 1);
        tick();
        wdata_valid = 0; W_ready = 0;
        exp_q.push_back({1'b0, 2'b00});
        B_valid = 1;
        tick();
        B_valid = 0;
        check_eq("wrap_done_id", done_id, 0);
`ifdef WMP_ERR_CNT_EN
        check_eq("b2b_err_cnt", err_cnt, 1);
`else
        check_eq("b2b_err_cnt", err_cnt, 0);
`endif
        tick();

        // W_ready toggling with a 2-beat burst.
        apply_reset("rst2");
        req_valid = 1; req_addr = 32'h0000_4000; req_len = 8'd1;
        tick();
        req_valid = 0; AW_grant = 1;
        tick();
        AW_grant = 0;
        tick();
        W_grant = 1;
        tick();
        W_grant = 0;
        hs_base = hs_cnt;
        wdata_valid = 1; wdata = 32'hAAAA_0000; W_ready = 0;
        #1;
        check_eq("tog_valid0", W_valid, 1);
        check_eq("tog_wready0", wdata_ready, 0);
        check_eq("tog_last0", W_last, 0);
        tick();
        W_ready = 1;
        #1;
        check_eq("tog_wready1", wdata_ready, 1);
        check_eq("tog_last1", W_last, 0);
        tick();
        wdata = 32'hAAAA_0001; W_ready = 0;
        #1;
        check_eq("tog_wready2", wdata_ready, 0);
        check_eq("tog_last2", W_last, 1);
        check_eq("tog_data2", W_data, 32'hAAAA_0001);
        tick();
        W_ready = 1;
        #1;
        check_eq("tog_wready3", wdata_ready, 1);
        check_eq("tog_last3", W_last, 1);
        tick();
        #1;
        check_eq("tog_resp_valid", W_valid, 0);
        check_eq("tog_hs_count", hs_cnt - hs_base, 2);
        wdata_valid = 0; W_ready = 0;
        exp_q.push_back({1'b0, 2'b01});
        B_valid = 1; B_resp = 2'b01;
        tick();
        B_valid = 0; B_resp = 0;
        check_eq("tog_done", done_valid, 1);
        tick();

        // Reset during the second data beat drops the transaction.
        apply_reset("rst3");
        req_valid = 1; req_addr = 32'h0000_5000; req_len = 8'd3;
        tick();
        req_valid = 0; AW_grant = 1;
        tick();
        AW_grant = 0;
        tick();
        W_grant = 1;
        tick();
        W_grant = 0;
        wdata_valid = 1; W_ready = 1; wdata = 32'h5555_0000;
        tick();
        wdata = 32'h5555_0001;
        #1;
        check_eq("mid_beat2_valid", W_valid, 1);
        clr = 0;
        #1;
        check_all_zero("midrst");
        drive_idle();
        tick();
        check_eq("midrst_no_done", done_valid, 0);
        tick();
        clr = 1;
        tick();
        run_write("after_rst", 32'h0000_6000, 8'd0, 2'b00, 1'b0);

        // Error counter.
        apply_reset("rst4");
        for (int i = 0; i < 3; i++) run_write("err", 32'h0000_7000 + AW'(i), 8'd0, 2'b10, IDW'(i));
`ifdef WMP_ERR_CNT_EN
        check_eq("err_cnt3", err_cnt, 3);
        for (int i = 3; i < 300; i++) run_write("err_sat", 32'h0000_8000, 8'd0, 2'b11, IDW'(i));
        check_eq("err_cnt_sat", err_cnt, 255);
`else
        check_eq("err_cnt_off", err_cnt, 0);
`endif
        check_eq("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/write_master_port.md
# write_master_port

Per-master write-side front end for the AXI interconnect. It accepts simple write requests from a master core and sequences the AW, W and B phases against `write_arbiter`'s grant protocol. It allocates transaction IDs, drives `AW_valid`/`AW_id`/`W_id`/`B_ready` into the arbiter and streams write beats once `W_grant` arrives. One instance sits directly upstream of each arbiter master slot.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, write data width.
- `NUM_OUTSTANDING_TRANS`, 2, max in-flight transactions (power of two, ≥2); `IDW = $clog2(NUM_OUTSTANDING_TRANS)`.

Ports:
- `clk` in 1: clock, rising edge.
- `clr` in 1: reset, asynchronous, active-low.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_addr` in ADDR_WIDTH: write address.
- `req_len` in 8: beats minus 1 (0 = 1 beat, 255 = 256 beats).
- `wdata` in DATA_WIDTH, `wdata_valid` in 1, `wdata_ready` out 1: user beat stream.
- `AW_valid` out 1, `AW_addr` out ADDR_WIDTH, `AW_id` out IDW, `AW_grant` in 1: to/from arbiter.
- `W_id` out IDW, `B_ready` out 1, `W_grant` in 1: to/from arbiter.
- `W_data` out DATA_WIDTH, `W_valid` out 1, `W_last` out 1, `W_ready` in 1: to slave via W mux.
- `B_valid` in 1, `B_resp` in 2: from slave via B mux.
- `done_valid` out 1, `done_id` out IDW, `done_resp` out 2: completion pulse.
- `err_cnt` out 8: error counter (see Configuration).

## Operation
- ID allocation: `next_id` counter, +1 per accepted request, wraps modulo NUM_OUTSTANDING_TRANS.
- In-order queue: depth NUM_OUTSTANDING_TRANS, entries {id, len}. It is pushed on the AW handshake and popped on B completion.
- `req_ready = (aw_state == AW_IDLE) && (occupancy + aw_pending < NUM_OUTSTANDING_TRANS)`.
- AW FSM:
  - AW_IDLE: on `req_valid && req_ready`, register addr, len and `next_id`, then go to AW_REQ.
  - AW_REQ: `AW_valid = 1` with registered addr and id. On `AW_grant`, push the queue and return to AW_IDLE; `AW_valid` is low the next cycle, which releases the arbiter's AW_ALLOW.
- W FSM:
  - W_IDLE: if the queue is non-empty, load `W_id` = head id and beat counter = head len, then go to W_REQ.
  - W_REQ: `B_ready = 1`, hold `W_id`. On `W_grant`, go to W_DATA.
  - W_DATA: combinational passthrough `W_valid = wdata_valid`, `W_data = wdata`, `wdata_ready = W_ready`. `W_last = (cnt == 0)`. On each `W_valid && W_ready`, decrement `cnt`; the handshake with `W_last` moves to W_RESP. `B_ready = 1`.
  - W_RESP: `B_ready = 1`. On `B_valid`, capture `B_resp`, pop the queue, pulse `done_valid` with `done_id` = head id for 1 cycle, and go to W_IDLE.
- `wdata_ready = 0` and `W_valid = 0` outside W_DATA.
- Push and pop in the same cycle: occupancy is unchanged and both take effect.
- Queue full: `req_ready = 0` and the AW FSM holds in AW_IDLE.
- Reset mid-operation: all FSMs go to IDLE, the queue empties, `next_id = 0`, and in-flight transactions are dropped without `done_valid`.

## Timing
- Reset values:
  - All outputs 0: `AW_valid`, `AW_addr`, `AW_id`, `W_id`, `B_ready`, `W_valid`, `W_last`, `W_data` (follows `wdata` only in W_DATA, else 0), `wdata_ready`, `done_*`, `err_cnt`.
  - `req_ready` is 1 one cycle after reset release.
- Request to `AW_valid`: 1 cycle (request registered at edge N, `AW_valid` high from N).
- `AW_grant` seen at edge N: `AW_valid` low after N. With the arbiter, AW accept takes ≥3 cycles.
- Queue push at edge N: W_IDLE sees non-empty after N, and `B_ready` rises one cycle later.
- Data beats: 1 beat per cycle maximum while `wdata_valid && W_ready`.
- `done_valid`: registered, high exactly 1 cycle, in the cycle after the `B_valid` edge.
- Back-to-back AW requests: 1 idle cycle minimum between `AW_valid` pulses.

## Configuration
- `WMP_ERR_CNT_EN`:
  - Defined: `err_cnt` is an 8-bit saturating counter, incremented on each completion with `B_resp != 2'b00`. It holds at 255 and is cleared only by `clr`.
  - Undefined: `err_cnt` is tied to 0 and no counter logic is built.

## Test plan
- Single write: `req_addr = 0x0001_0010`, `req_len = 3`, AW/W grants supplied per arbiter protocol → `AW_id = 0`, 4 beats with `W_last` on beat 4 only, `done_valid` 1 cycle with `done_id = 0`, `done_resp = 0`.
- Two back-to-back requests (N = 2) → IDs 0 then 1. `req_ready = 0` after the second until the first `done_valid`. W phases are issued in order with `W_id` 0 then 1.
- Third request while 2 are outstanding → stalls with `req_ready = 0`. It is accepted the cycle after the first completion, with `AW_id = 0` (wrap).
- `W_ready` toggling every other cycle with `req_len = 1` → exactly 2 data handshakes, `wdata_ready` mirrors `W_ready`, `W_last` only on the second beat.
- `clr` asserted during W_DATA beat 2 → all outputs 0 immediately, no `done_valid`. The next request gets `AW_id = 0`.
- With `WMP_ERR_CNT_EN`: 3 completions with `B_resp = 2'b10` → `err_cnt = 3`. 300 errors → `err_cnt = 255`. Without the macro → `err_cnt = 0`.
